// File: rtl/writeback_stage_if.sv
// Writeback-stage bus bundle: issue/scoreboard query, ALU and load result inputs,
// and the register-file write port. The slave modport is the writeback stage itself.
interface writeback_stage_if;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_busy;
  logic        byp_hit1;
  logic        byp_hit2;
  logic        w_en;
  logic [4:0]  rd;
  logic [31:0] w_data;

  modport master (
    output iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, rs1, rs2,
    input  alu_ready, ld_ready, rs1_busy, rs2_busy, rd_busy,
    input  byp_hit1, byp_hit2, w_en, rd, w_data
  );

  modport slave (
    input  iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, rs1, rs2,
    output alu_ready, ld_ready, rs1_busy, rs2_busy, rd_busy,
    output byp_hit1, byp_hit2, w_en, rd, w_data
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback arbiter for the 32x32 register file: load FIFO, ALU/load arbitration with
// ALU anti-starvation, and a busy scoreboard. Define WB_BYPASS_EN to enable w_data bypass hits.
module writeback_stage #(
  parameter int unsigned LD_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  writeback_stage_if.slave wb
);

  localparam int unsigned PTR_W = $clog2(LD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_ent_t;

  ld_ent_t           r_mem [LD_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [ST_W-1:0]   r_starve;
  logic [31:1]       r_busy;
  logic              r_w_en;
  logic [4:0]        r_rd;
  logic [31:0]       r_w_data;

  logic              w_empty;
  logic              w_full;
  logic              w_ld_win;
  logic              w_alu_ready;
  logic              w_alu_win;
  logic              w_push;
  logic              w_pop;
  logic              w_win;
  ld_ent_t           w_head;
  logic [4:0]        w_win_rd;
  logic [31:0]       w_win_data;
  logic [31:1]       w_busy_nxt;
  logic [31:0]       w_busy_all;
  logic              w_byp1;
  logic              w_byp2;

  // Loads win whenever buffered, unless the ALU has already lost STARVE_MAX times in a row
  always_comb begin
    w_empty     = (r_cnt == '0);
    w_full      = (r_cnt == CNT_W'(LD_DEPTH));
    w_head      = r_mem[r_rptr];
    w_ld_win    = !w_empty && (r_starve < ST_W'(STARVE_MAX));
    w_alu_ready = !w_ld_win;
    w_alu_win   = wb.alu_valid && w_alu_ready;
    w_push      = wb.ld_valid && !w_full;
    w_pop       = w_ld_win;
    w_win       = w_ld_win || w_alu_win;
    w_win_rd    = w_ld_win ? w_head.rd   : wb.alu_rd;
    w_win_data  = w_ld_win ? w_head.data : wb.alu_data;
  end

  // Scoreboard next state: a same-cycle issue to the register being written keeps it busy
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned i = 1; i < 32; i++) begin
      if (r_w_en && (r_rd == 5'(i)))
        w_busy_nxt[i] = 1'b0;
      if (wb.iss_valid && (wb.iss_rd == 5'(i)))
        w_busy_nxt[i] = 1'b1;
    end
  end

  always_comb begin
    w_busy_all = {r_busy, 1'b0};
`ifdef WB_BYPASS_EN
    w_byp1 = r_w_en && (r_rd != 5'd0) && (wb.rs1 == r_rd);
    w_byp2 = r_w_en && (r_rd != 5'd0) && (wb.rs2 == r_rd);
`else
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
`endif
  end

  assign wb.alu_ready = w_alu_ready;
  assign wb.ld_ready  = !w_full;
  assign wb.rs1_busy  = w_busy_all[wb.rs1] && !w_byp1;
  assign wb.rs2_busy  = w_busy_all[wb.rs2] && !w_byp2;
  assign wb.rd_busy   = w_busy_all[wb.iss_rd];
  assign wb.byp_hit1  = w_byp1;
  assign wb.byp_hit2  = w_byp2;
  assign wb.w_en      = r_w_en;
  assign wb.rd        = r_rd;
  assign wb.w_data    = r_w_data;

  // FIFO storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= '{rd: wb.ld_rd, data: wb.ld_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_busy   <= '0;
      r_w_en   <= 1'b0;
      r_rd     <= '0;
      r_w_data <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - CNT_W'(1);

      if (w_alu_win)
        r_starve <= '0;
      else if (wb.alu_valid && (r_starve < ST_W'(STARVE_MAX)))
        r_starve <= r_starve + ST_W'(1);

      r_busy <= w_busy_nxt;

      // x0 results consume their slot but never write
      r_w_en <= w_win && (w_win_rd != 5'd0);
      if (w_win) begin
        r_rd     <= w_win_rd;
        r_w_data <= w_win_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a queue-based behavioural model.
module tb_writeback_stage;

  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_stage_if u_if();

  writeback_stage dut (
    .clk (clk),
    .rst (rst),
    .wb  (u_if)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  // Model state
  ent_t        mq[$];
  int          m_starve;
  bit [31:0]   m_busy;
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  bit          m_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ldwin();
    return (mq.size() != 0) && (m_starve < SMAX);
  endfunction

  task automatic compare_model();
    bit h1, h2;
    if (!m_ok) return;
    h1 = 1'b0;
    h2 = 1'b0;
`ifdef WB_BYPASS_EN
    h1 = m_wen && (m_rd != 0) && (u_if.rs1 == m_rd);
    h2 = m_wen && (m_rd != 0) && (u_if.rs2 == m_rd);
`endif
    chk("alu_ready", 32'(u_if.alu_ready), 32'(!m_ldwin()));
    chk("ld_ready",  32'(u_if.ld_ready),  32'(mq.size() < DEPTH));
    chk("rs1_busy",  32'(u_if.rs1_busy),  32'(m_busy[u_if.rs1] && !h1));
    chk("rs2_busy",  32'(u_if.rs2_busy),  32'(m_busy[u_if.rs2] && !h2));
    chk("rd_busy",   32'(u_if.rd_busy),   32'(m_busy[u_if.iss_rd]));
    chk("byp_hit1",  32'(u_if.byp_hit1),  32'(h1));
    chk("byp_hit2",  32'(u_if.byp_hit2),  32'(h2));
    chk("w_en",      32'(u_if.w_en),      32'(m_wen));
    chk("rd",        32'(u_if.rd),        32'(m_rd));
    chk("w_data",    u_if.w_data,         m_wd);
  endtask

  task automatic model_update();
    ent_t      w;
    bit        win, lw, ldr;
    bit [31:0] nb;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      m_busy   = '0;
      m_wen    = 1'b0;
      m_rd     = '0;
      m_wd     = '0;
      m_ok     = 1'b1;
      return;
    end
    if (!m_ok) return;
    lw  = m_ldwin();
    ldr = (mq.size() < DEPTH);
    win = 1'b0;
    w   = '0;
    if (lw) begin
      w   = mq.pop_front();
      win = 1'b1;
      if (u_if.alu_valid) m_starve++;
    end else if (u_if.alu_valid) begin
      w.rd     = u_if.alu_rd;
      w.d      = u_if.alu_data;
      win      = 1'b1;
      m_starve = 0;
    end
    if (u_if.ld_valid && ldr) mq.push_back({u_if.ld_rd, u_if.ld_data});
    nb = m_busy;
    if (m_wen) nb[m_rd] = 1'b0;
    if (u_if.iss_valid && (u_if.iss_rd != 0)) nb[u_if.iss_rd] = 1'b1;
    m_busy = nb;
    if (win) begin
      m_wen = (w.rd != 0);
      m_rd  = w.rd;
      m_wd  = w.d;
    end else begin
      m_wen = 1'b0;
    end
  endtask

  task automatic idle();
    rst            = 1'b0;
    u_if.iss_valid = 1'b0;
    u_if.iss_rd    = '0;
    u_if.alu_valid = 1'b0;
    u_if.alu_rd    = '0;
    u_if.alu_data  = '0;
    u_if.ld_valid  = 1'b0;
    u_if.ld_rd     = '0;
    u_if.ld_data   = '0;
    u_if.rs1       = '0;
    u_if.rs2       = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Compare against the model, advance it across the posedge, return at the next negedge
  task automatic tick();
    compare_model();
    model_update();
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    bit [4:0] pat;
    idle();
    rst = 1'b1;
    @(negedge clk);
    cyc();

    // Reset state
    idle();
    settle();
    chk("rst_w_en", 32'(u_if.w_en), 32'd0);
    chk("rst_ld_ready", 32'(u_if.ld_ready), 32'd1);
    chk("rst_alu_ready", 32'(u_if.alu_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      u_if.rs1 = 5'(i);
      #1;
      chk($sformatf("rst_rs1_busy%0d", i), 32'(u_if.rs1_busy), 32'd0);
    end
    u_if.rs1 = '0;
    tick();

    // Single ALU write to x5
    idle(); u_if.iss_valid = 1'b1; u_if.iss_rd = 5'd5;
    cyc();
    idle(); u_if.rs1 = 5'd5;
    settle();
    chk("alu1_busy_c1", 32'(u_if.rs1_busy), 32'd1);
    tick();
    idle(); u_if.rs1 = 5'd5;
    u_if.alu_valid = 1'b1; u_if.alu_rd = 5'd5; u_if.alu_data = 32'hDEADBEEF;
    settle();
    chk("alu1_ready_c2", 32'(u_if.alu_ready), 32'd1);
    chk("alu1_busy_c2", 32'(u_if.rs1_busy), 32'd1);
    tick();
    idle(); u_if.rs1 = 5'd5;
    settle();
    chk("alu1_w_en_c3", 32'(u_if.w_en), 32'd1);
    chk("alu1_rd_c3", 32'(u_if.rd), 32'd5);
    chk("alu1_w_data_c3", u_if.w_data, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
    chk("alu1_busy_c3", 32'(u_if.rs1_busy), 32'd0);
    chk("alu1_byp_c3", 32'(u_if.byp_hit1), 32'd1);
`else
    chk("alu1_busy_c3", 32'(u_if.rs1_busy), 32'd1);
    chk("alu1_byp_c3", 32'(u_if.byp_hit1), 32'd0);
`endif
    tick();
    idle(); u_if.rs1 = 5'd5;
    settle();
    chk("alu1_busy_c4", 32'(u_if.rs1_busy), 32'd0);
    chk("alu1_w_en_c4", 32'(u_if.w_en), 32'd0);
    tick();

    // Starvation: ALU loses exactly three times, wins once, then loads resume
    idle(); u_if.ld_valid = 1'b1; u_if.ld_rd = 5'd12; u_if.ld_data = 32'h100;
    cyc();
    pat = 5'b01000;
    for (int k = 0; k < 7; k++) begin
      idle();
      u_if.alu_valid = 1'b1; u_if.alu_rd = 5'd11; u_if.alu_data = 32'hA0 + 32'(k);
      u_if.ld_valid  = 1'b1; u_if.ld_rd  = 5'd12; u_if.ld_data  = 32'h101 + 32'(k);
      settle();
      if (k < 5) chk($sformatf("starve_rdy%0d", k), 32'(u_if.alu_ready), 32'(pat[k]));
      tick();
    end

    // Fill the FIFO while the ALU sits at the starve limit, then force the ALU through
    for (int j = 0; j < 2; j++) begin
      idle(); u_if.ld_valid = 1'b1; u_if.ld_rd = 5'd12; u_if.ld_data = 32'h108 + 32'(j);
      cyc();
    end
    idle(); u_if.ld_valid = 1'b1; u_if.ld_rd = 5'd12; u_if.ld_data = 32'h10A;
    u_if.alu_valid = 1'b1; u_if.alu_rd = 5'd13; u_if.alu_data = 32'hB0;
    settle();
    chk("full_ld_ready_f1", 32'(u_if.ld_ready), 32'd0);
    chk("full_alu_ready_f1", 32'(u_if.alu_ready), 32'd1);
    tick();
    idle(); u_if.ld_valid = 1'b1; u_if.ld_rd = 5'd12; u_if.ld_data = 32'h10A;
    settle();
    chk("full_ld_ready_f2", 32'(u_if.ld_ready), 32'd0);
    chk("full_alu_ready_f2", 32'(u_if.alu_ready), 32'd0);
    chk("full_w_data_f2", u_if.w_data, 32'hB0);
    tick();
    idle(); u_if.ld_valid = 1'b1; u_if.ld_rd = 5'd12; u_if.ld_data = 32'h10A;
    settle();
    chk("full_ld_ready_f3", 32'(u_if.ld_ready), 32'd1);
    chk("full_w_data_f3", u_if.w_data, 32'h106);
    tick();
    for (int j = 0; j < 8; j++) begin
      idle();
      cyc();
    end

    // x0 result is accepted but never written
    idle(); u_if.alu_valid = 1'b1; u_if.alu_rd = 5'd0; u_if.alu_data = 32'h55;
    settle();
    chk("x0_alu_ready", 32'(u_if.alu_ready), 32'd1);
    tick();
    idle();
    settle();
    chk("x0_w_en", 32'(u_if.w_en), 32'd0);
    tick();

    // Set/clear collision on x7
    idle(); u_if.iss_valid = 1'b1; u_if.iss_rd = 5'd7;
    cyc();
    idle(); u_if.alu_valid = 1'b1; u_if.alu_rd = 5'd7; u_if.alu_data = 32'h77;
    cyc();
    idle(); u_if.iss_valid = 1'b1; u_if.iss_rd = 5'd7;
    settle();
    chk("coll_w_en", 32'(u_if.w_en), 32'd1);
    chk("coll_rd", 32'(u_if.rd), 32'd7);
    tick();
    idle(); u_if.rs1 = 5'd7;
    settle();
    chk("coll_busy7", 32'(u_if.rs1_busy), 32'd1);
    tick();

    // Reset with buffered loads and busy {3,4}
    idle(); u_if.iss_valid = 1'b1; u_if.iss_rd = 5'd3;
    cyc();
    idle(); u_if.iss_valid = 1'b1; u_if.iss_rd = 5'd4;
    cyc();
    idle(); u_if.ld_valid = 1'b1; u_if.ld_rd = 5'd20; u_if.ld_data = 32'h200;
    cyc();
    for (int k = 0; k < 3; k++) begin
      idle();
      u_if.alu_valid = 1'b1; u_if.alu_rd = 5'd21; u_if.alu_data = 32'hC0 + 32'(k);
      u_if.ld_valid  = 1'b1; u_if.ld_rd  = 5'd20; u_if.ld_data  = 32'h201 + 32'(k);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      idle(); u_if.ld_valid = 1'b1; u_if.ld_rd = 5'(3 + k); u_if.ld_data = 32'h300 + 32'(k);
      cyc();
    end
    idle(); rst = 1'b1; u_if.rs1 = 5'd3; u_if.rs2 = 5'd4;
    settle();
    chk("pre_rst_busy3", 32'(u_if.rs1_busy), 32'd1);
    chk("pre_rst_busy4", 32'(u_if.rs2_busy), 32'd1);
    chk("pre_rst_alu_ready", 32'(u_if.alu_ready), 32'd1);
    tick();
    idle();
    settle();
    chk("post_rst_alu_ready", 32'(u_if.alu_ready), 32'd1);
    chk("post_rst_ld_ready", 32'(u_if.ld_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      u_if.rs1 = 5'(i);
      u_if.rs2 = 5'(31 - i);
      #1;
      chk($sformatf("post_rst_busy%0d", i), 32'(u_if.rs1_busy | u_if.rs2_busy), 32'd0);
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      idle();
      settle();
      chk($sformatf("post_rst_w_en%0d", j), 32'(u_if.w_en), 32'd0);
      tick();
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      u_if.iss_valid = 1'($urandom_range(0, 1));
      u_if.iss_rd    = 5'($urandom);
      u_if.alu_valid = 1'($urandom_range(0, 1));
      u_if.alu_rd    = 5'($urandom);
      u_if.alu_data  = $urandom;
      u_if.ld_valid  = ($urandom_range(0, 9) < 4);
      u_if.ld_rd     = 5'($urandom);
      u_if.ld_data   = $urandom;
      u_if.rs1       = 5'($urandom);
      u_if.rs2       = 5'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
